// File: rtl/matrix_serializer_pkg.sv
// Shared definitions for the matrix serializer: FSM state encoding, scan
// mode constants and an index-width helper used to size counters and ports.
package matrix_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

  // Width needed to address n items; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Element sequencer for the matrix serializer.
// Walks k = 0..N-1 and keeps row/column counters that wrap, producing the
// linear position r*COLS+c of element k without any divider or multiplier.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   clear_i    restart the sequence at element 0 (frame load)
//   step_i     advance to the next element (transfer accepted)
//   mode_i     ROW_MAJOR or COL_MAJOR scan order
//   index_o    linear position r*COLS+c of the current element
//   last_o     current element is k = N-1
module matrix_index_counter
  import matrix_serializer_pkg::*;
#(
  parameter  int unsigned ROWS = 4,
  parameter  int unsigned COLS = 4,
  localparam int unsigned N    = ROWS * COLS,
  localparam int unsigned IW   = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          step_i,
  input  logic          mode_i,
  output logic [IW-1:0] index_o,
  output logic          last_o
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned CW = idx_width(COLS);

  localparam logic [RW-1:0] R_MAX   = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_MAX   = CW'(COLS - 1);
  localparam logic [IW-1:0] K_MAX   = IW'(N - 1);
  localparam logic [IW-1:0] ROW_STR = IW'(COLS);

  logic [IW-1:0] k_q,   k_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RW-1:0] r_q,   r_d;
  logic [CW-1:0] c_q,   c_d;

  assign last_o  = (k_q == K_MAX);
  assign index_o = idx_q;

  // The linear index is tracked incrementally: +1 in row-major order,
  // +COLS down a column, and restarting at the new column number (row 0)
  // when the column wraps. Stepping past the last element returns to 0
  // so the counters never wrap inside a frame.
  always_comb begin
    k_d   = k_q;
    idx_d = idx_q;
    r_d   = r_q;
    c_d   = c_q;
    if (clear_i || (step_i && last_o)) begin
      k_d   = '0;
      idx_d = '0;
      r_d   = '0;
      c_d   = '0;
    end else if (step_i) begin
      k_d = k_q + 1'b1;
      if (mode_i == ROW_MAJOR) begin
        idx_d = idx_q + 1'b1;
        if (c_q == C_MAX) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end else begin
        if (r_q == R_MAX) begin
          r_d   = '0;
          c_d   = c_q + 1'b1;
          idx_d = IW'(c_q) + 1'b1;
        end else begin
          r_d   = r_q + 1'b1;
          idx_d = idx_q + ROW_STR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      idx_q <= '0;
      r_q   <= '0;
      c_q   <= '0;
    end else begin
      k_q   <= k_d;
      idx_q <= idx_d;
      r_q   <= r_d;
      c_q   <= c_d;
    end
  end

endmodule

// File: rtl/matrix_serializer.sv
// Matrix serializer: captures a ROWS x COLS bit matrix and streams it out one
// element per transfer in row-major or column-major order, with a
// valid/ready handshake on both sides.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   load_valid    producer offers a matrix (with mode)
//   load_ready    block is idle and can accept a matrix
//   matrix        input matrix, element L[r][c] = matrix[r][c]
//   mode          0 = row-major, 1 = column-major
//   out_valid     out_bit/out_index/out_last are valid
//   out_ready     consumer accepts the current element
//   out_bit       current element value
//   out_index     linear position r*COLS+c of the current element
//   out_last      current element is the final one of the frame
module matrix_serializer
  import matrix_serializer_pkg::*;
#(
  parameter  int unsigned ROWS = 4,
  parameter  int unsigned COLS = 4,
  localparam int unsigned N    = ROWS * COLS,
  localparam int unsigned IW   = idx_width(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [ROWS-1:0][COLS-1:0] matrix,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_bit,
  output logic [IW-1:0]             out_index,
  output logic                      out_last
);

  // Matrix bits padded to a power of two so out_index selects exactly.
  localparam int unsigned PW = 1 << IW;

  state_e                    state_q;
  logic [ROWS-1:0][COLS-1:0] mat_q;
  logic                      mode_q;
  logic [PW-1:0]             flat;
  logic                      load_fire;
  logic                      xfer;
  logic                      last;

  assign load_fire = (state_q == IDLE) && load_valid;
  assign xfer      = (state_q == SEND) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      mode_q  <= ROW_MAJOR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            mat_q   <= matrix;
            mode_q  <= mode;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready && last) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  matrix_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (load_fire),
    .step_i  (xfer),
    .mode_i  (mode_q),
    .index_o (out_index),
    .last_o  (last)
  );

  // Packed layout puts L[r][c] at bit r*COLS+c, i.e. exactly out_index.
  assign flat       = PW'(mat_q);
  assign load_ready = (state_q == IDLE);
  assign out_valid  = (state_q == SEND);
  assign out_bit    = out_valid & flat[out_index];
  assign out_last   = out_valid & last;

endmodule

// File: tb/tb_matrix_serializer.sv
module tb_matrix_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4 instance
  logic            load_valid_a = 1'b0, load_ready_a, mode_a = 1'b0;
  logic [3:0][3:0] matrix_a = '0;
  logic            out_valid_a, out_ready_a = 1'b1, out_bit_a, out_last_a;
  logic [3:0]      out_index_a;

  // 2x3 instance
  logic            load_valid_b = 1'b0, load_ready_b, mode_b = 1'b0;
  logic [1:0][2:0] matrix_b = '0;
  logic            out_valid_b, out_ready_b = 1'b1, out_bit_b, out_last_b;
  logic [2:0]      out_index_b;

  // 1x1 instance
  logic            load_valid_c = 1'b0, load_ready_c, mode_c = 1'b0;
  logic [0:0][0:0] matrix_c = '0;
  logic            out_valid_c, out_ready_c = 1'b1, out_bit_c, out_last_c;
  logic [0:0]      out_index_c;

  matrix_serializer #(.ROWS(4), .COLS(4)) dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid_a), .load_ready(load_ready_a),
    .matrix(matrix_a), .mode(mode_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_bit(out_bit_a), .out_index(out_index_a), .out_last(out_last_a));

  matrix_serializer #(.ROWS(2), .COLS(3)) dut_b (
    .clk(clk), .rst(rst), .load_valid(load_valid_b), .load_ready(load_ready_b),
    .matrix(matrix_b), .mode(mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_bit(out_bit_b), .out_index(out_index_b), .out_last(out_last_b));

  matrix_serializer #(.ROWS(1), .COLS(1)) dut_c (
    .clk(clk), .rst(rst), .load_valid(load_valid_c), .load_ready(load_ready_c),
    .matrix(matrix_c), .mode(mode_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_bit(out_bit_c), .out_index(out_index_c), .out_last(out_last_c));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        mode;
    logic [15:0] mat;   // bit r*4+c = L[r][c]
    logic [63:0] idx;   // nibble k = expected out_index of element k
    logic [15:0] bits;  // bit k = expected out_bit of element k
    logic [3:0]  pat;   // out_ready per cycle, cycling through bits 0..3
  } frame_t;

  localparam logic [63:0] ROW_SEQ = 64'hFEDCBA9876543210;
  localparam logic [63:0] COL_SEQ = 64'hFB73EA62D951C840;

  frame_t frames[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " out_valid"},  32'(out_valid_a),  32'd0);
    chk({tag, " load_ready"}, 32'(load_ready_a), 32'd1);
    chk({tag, " out_last"},   32'(out_last_a),   32'd0);
  endtask

  task automatic load_a(input logic m, input logic [15:0] mat);
    chk("load_ready before load", 32'(load_ready_a), 32'd1);
    load_valid_a = 1'b1;
    mode_a       = m;
    matrix_a     = mat;
    tick;
    load_valid_a = 1'b0;
  endtask

  // Drain one frame from dut_a, comparing every cycle (including stalls).
  task automatic run_elems(input string tag, input logic [63:0] idx,
                           input logic [15:0] bits, input logic [3:0] pat);
    int k   = 0;
    int cyc = 0;
    while (k < 16 && cyc < 64) begin
      chk({tag, " out_valid"}, 32'(out_valid_a), 32'd1);
      chk({tag, " out_index"}, 32'(out_index_a), 32'(idx[4*k +: 4]));
      chk({tag, " out_bit"},   32'(out_bit_a),   32'(bits[k]));
      chk({tag, " out_last"},  32'(out_last_a),  32'(k == 15));
      out_ready_a = pat[cyc % 4];
      tick;
      if (out_ready_a) k++;
      cyc++;
    end
    chk({tag, " transfers"}, 32'(k), 32'd16);
    out_ready_a = 1'b1;
  endtask

  initial begin
    int exp_b[6];

    frames[0] = '{"row_single", 1'b0, 16'h0001, ROW_SEQ, 16'h0001, 4'b1111};
    frames[1] = '{"col_single", 1'b1, 16'h0001, COL_SEQ, 16'h0001, 4'b1111};
    frames[2] = '{"row_stall",  1'b0, 16'h0001, ROW_SEQ, 16'h0001, 4'b1001};
    frames[3] = '{"row_mixed",  1'b0, 16'hA5C3, ROW_SEQ, 16'hA5C3, 4'b1111};
    frames[4] = '{"col_stall",  1'b1, 16'h00FF, COL_SEQ, 16'h3333, 4'b0110};

    // Reset state
    tick;
    tick;
    rst = 1'b0;
    chk("reset load_ready", 32'(load_ready_a), 32'd1);
    chk("reset out_valid",  32'(out_valid_a),  32'd0);
    chk("reset out_bit",    32'(out_bit_a),    32'd0);
    chk("reset out_index",  32'(out_index_a),  32'd0);
    chk("reset out_last",   32'(out_last_a),   32'd0);

    // Table-driven frames
    foreach (frames[i]) begin
      load_a(frames[i].mode, frames[i].mat);
      run_elems(frames[i].name, frames[i].idx, frames[i].bits, frames[i].pat);
      chk_idle_a({frames[i].name, " after"});
    end

    // load_valid held through SEND with a different matrix and mode
    load_valid_a = 1'b1;
    mode_a       = 1'b0;
    matrix_a     = 16'h0000;
    tick;
    matrix_a     = 16'hFFFF;
    mode_a       = 1'b1;
    run_elems("hold_first", ROW_SEQ, 16'h0000, 4'b1111);
    chk_idle_a("hold gap");
    tick;
    load_valid_a = 1'b0;
    run_elems("hold_second", COL_SEQ, 16'hFFFF, 4'b1111);
    chk_idle_a("hold after");

    // Reset after 5 transfers aborts the frame
    load_a(1'b0, 16'hFFFF);
    repeat (5) tick;
    chk("pre-abort out_index", 32'(out_index_a), 32'd5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort out_valid",  32'(out_valid_a),  32'd0);
    chk("abort load_ready", 32'(load_ready_a), 32'd1);
    chk("abort out_index",  32'(out_index_a),  32'd0);
    chk("abort out_bit",    32'(out_bit_a),    32'd0);
    chk("abort out_last",   32'(out_last_a),   32'd0);
    tick;
    chk("abort stays idle", 32'(out_valid_a), 32'd0);
    load_a(1'b1, 16'h0001);
    run_elems("post_abort", COL_SEQ, 16'h0001, 4'b1111);
    chk_idle_a("post_abort after");

    // Reset wins over load_valid in the same cycle
    load_valid_a = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    load_valid_a = 1'b0;
    chk("rst priority out_valid", 32'(out_valid_a), 32'd0);

    // 2x3 column-major, all ones
    exp_b = '{0, 3, 1, 4, 2, 5};
    load_valid_b = 1'b1;
    mode_b       = 1'b1;
    matrix_b     = 6'b111111;
    tick;
    load_valid_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("2x3 out_valid", 32'(out_valid_b), 32'd1);
      chk("2x3 out_index", 32'(out_index_b), 32'(exp_b[k]));
      chk("2x3 out_bit",   32'(out_bit_b),   32'd1);
      chk("2x3 out_last",  32'(out_last_b),  32'(k == 5));
      tick;
    end
    chk("2x3 after out_valid", 32'(out_valid_b), 32'd0);

    // 1x1: single element is last, held during a stall
    load_valid_c = 1'b1;
    matrix_c     = 1'b1;
    out_ready_c  = 1'b0;
    tick;
    load_valid_c = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("1x1 out_valid", 32'(out_valid_c), 32'd1);
      chk("1x1 out_index", 32'(out_index_c), 32'd0);
      chk("1x1 out_bit",   32'(out_bit_c),   32'd1);
      chk("1x1 out_last",  32'(out_last_c),  32'd1);
      out_ready_c = (s == 1);
      tick;
    end
    chk("1x1 after out_valid",  32'(out_valid_c),  32'd0);
    chk("1x1 after load_ready", 32'(load_ready_c), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_serializer.md
MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of lines in the input matrix (>=1).
REQ-002 SHALL have parameter COLS, default 4, bits per line (>=1).
REQ-003 SHALL define N = ROWS*COLS and IW = max(1, clog2(N)), both derived, not overridable.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 load_valid  input  1  producer offers a matrix.
REQ-008 load_ready  output  1  block can accept a matrix.
REQ-009 matrix  input  [ROWS-1:0][COLS-1:0]  matrix L; element L[r][c].
REQ-010 mode  input  1  0 = row-major, 1 = column-major; sampled with matrix.
REQ-011 out_valid  output  1  out_bit/out_index/out_last valid.
REQ-012 out_ready  input  1  consumer accepts current element.
REQ-013 out_bit  output  1  current element value.
REQ-014 out_index  output  IW  linear position r*COLS+c of current element.
REQ-015 out_last  output  1  current element is final of the frame.

Function
REQ-016 SHALL implement FSM states IDLE and SEND.
REQ-017 IDLE: load_ready=1, out_valid=0; load_valid=1 captures matrix and mode into internal registers, clears element counter k to 0, moves to SEND.
REQ-018 SEND: load_ready=0, out_valid=1; load_valid ignored, captured data unaffected by input changes.
REQ-019 Latency: load accepted at edge t -> out_valid=1 with element k=0 in the cycle after t.
REQ-020 Row-major: element k maps to r=k/COLS, c=k%COLS; column-major: r=k%ROWS, c=k/ROWS.
REQ-021 out_bit = captured L[r][c]; out_index = r*COLS+c in both modes.
REQ-022 out_last = 1 iff out_valid and k = N-1.
REQ-023 Transfer occurs on an edge with out_valid & out_ready; k increments by 1 on each transfer.
REQ-024 out_valid=1 and out_ready=0: all outputs SHALL remain stable until transfer.
REQ-025 Transfer with out_last=1: return to IDLE, k=0; no wrap to element 0 within SEND.
REQ-026 Back-to-back frames: no bypass; at least one IDLE cycle between frames (N+1 cycles min per frame).
REQ-027 ROWS=1 or COLS=1 (incl. N=1) SHALL work; N=1 gives out_last=1 on the only element.
REQ-028 Row/column derivation SHALL use counters (r,c incrementing with wrap), no divider.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, k=0, r=0, c=0, captured matrix=0, mode=0.
REQ-030 Reset values: load_ready=1, out_valid=0, out_bit=0, out_index=0, out_last=0 in the cycle after reset.
REQ-031 Reset mid-frame SHALL abort the frame; no further elements of it emitted.
REQ-032 rst has priority over load_valid and out_ready in the same cycle.

Structure
REQ-033 Shared package SHALL hold the state enum (IDLE, SEND) and mode constants ROW_MAJOR=0, COL_MAJOR=1.
REQ-034 One sub-module matrix_index_counter SHALL generate k, r, c, out_index and last for given ROWS, COLS, mode.
REQ-035 No latches; all state in one always_ff on clk.

Verification
REQ-036 ROWS=COLS=4, mode=0, matrix rows L[0]=4'b0001, L[1..3]=0, out_ready=1 -> out_bit sequence 1 then 15 zeros, out_index 0..15, out_last at index 15.
REQ-037 Same matrix, mode=1 -> out_index sequence 0,4,8,12,1,5,...,15; out_bit=1 only at first element.
REQ-038 out_ready toggled 1,0,0,1 during frame -> outputs held during stalls, no element skipped or repeated, total 16 transfers.
REQ-039 load_valid held high during SEND with different matrix -> ignored; next frame starts after one IDLE cycle with the new matrix.
REQ-040 rst asserted after 5 transfers -> next cycle out_valid=0, load_ready=1; subsequent frame starts at index 0.
REQ-041 ROWS=2, COLS=3, mode=1, all-ones -> out_index 0,3,1,4,2,5, out_last on index 5.
